noc_input_unit: RTL and testbench
=================================

NOC_INPUT_UNIT -- requirements
Module: noc_input_unit

Interface
REQ-001 Parameter FLIT_W, 32, flit width; bits [FLIT_W-1:FLIT_W-2] are the type: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-002 Parameter DEPTH, 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameters LOCAL_X (1 bit) and LOCAL_Y (2 bits), both 0 by default, give this router's mesh coordinates.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  allocation-cycle enable, shared with the switch allocator.
REQ-006 in_valid  in  1, in_flit  in  FLIT_W, in_ready  out  1  upstream link.
REQ-007 dst  out  3  requested output port code, EMPTY when idle; dst_en  out  1  one-cycle pulse marking a new dst.
REQ-008 grant  in  1  the switch allocator has selected this port for the current cycle.
REQ-009 out_valid  out  1, out_flit  out  FLIT_W  flit toward the crossbar.
REQ-010 err  out  1  sticky protocol-error flag.

Function
REQ-011 Head flit fields: dst_x at bit [FLIT_W-3], dst_y at bits [FLIT_W-4:FLIT_W-5].
REQ-012 in_ready SHALL equal !full; push occurs when in_valid && in_ready; a push is never accepted while full, even if a pop happens in the same cycle.
REQ-013 The FIFO SHALL use wrapping pointers with an extra wrap bit; full and empty SHALL be derived from the pointers only.
REQ-014 The FSM SHALL have three states: IDLE, ROUTE and ACTIVE.
REQ-015 IDLE: dst=EMPTY; if en and the front entry is a head or single flit, go to ROUTE.
REQ-016 ROUTE (one cycle):
- route: dst_x!=LOCAL_X gives OUT_X1_PORT; else dst_y!=LOCAL_Y gives OUT_Y1_PORT; else OUT_LOCAL_PORT;
- dst is registered and dst_en=1 for exactly this cycle;
- go to ACTIVE.
REQ-017 ACTIVE: dst is held for the whole packet; when en && grant && !empty, pop the front flit; on the next cycle out_valid=1 and out_flit=the popped flit.
REQ-018 grant with an empty FIFO (mid-packet bubble): no pop; out_valid=0 next cycle; stay in ACTIVE.
REQ-019 Popping a tail or single flit: dst=EMPTY next cycle and go to IDLE; a following head needs a new ROUTE cycle, so there are at least 2 cycles between packets.
REQ-020 en=0 freezes the FSM, pops and dst; pushes continue; out_valid=0.
REQ-021 Simultaneous push and pop when neither full nor empty: both occur and the count is unchanged.
REQ-022 grant in IDLE or ROUTE SHALL be ignored.

Reset
REQ-023 Asserting rst_n low at any time, including mid-packet, SHALL cause:
- FIFO emptied, FSM to IDLE;
- dst=EMPTY, dst_en=0, out_valid=0, out_flit=0, err=0, in_ready=1;
- any partially received packet discarded.

Configuration
REQ-024 With NOC_IU_ERR_CHK_EN defined:
- in IDLE, a front body or tail flit SHALL be popped and dropped with err set (sticky until reset);
- in ACTIVE, a popped head flit SHALL set err and be forwarded.
REQ-025 Without NOC_IU_ERR_CHK_EN: err is tied to 0; in IDLE, non-head front flits stall the FIFO until reset.

Structure
REQ-026 The shared global definitions file SHALL hold EMPTY, OUT_X1_PORT, OUT_Y1_PORT, OUT_LOCAL_PORT and the flit-type codes; no literal port codes in this module.
REQ-027 The FIFO SHALL be a sub-module named noc_flit_fifo (parameters FLIT_W, DEPTH); route compute and FSM stay in noc_input_unit.

Verification (LOCAL_X=0, LOCAL_Y=0, DEPTH=4)
REQ-028 Single flit with dst_x=1, grant held high:
- dst=OUT_X1_PORT with dst_en pulse 1 cycle after IDLE detect;
- out_valid 1 cycle after grant;
- dst=EMPTY the cycle after the pop.
REQ-029 Head/body/body/tail with dst=(0,2):
- dst=OUT_Y1_PORT held for 4 pops;
- grant toggled 1010…: pops only on grant cycles, flits in order;
- exactly one dst_en pulse.
REQ-030 Five flits pushed back-to-back with no grant:
- in_ready=0 after the 4th;
- 5th held upstream until the first pop;
- no flit lost or duplicated.
REQ-031 Packet to (0,0) with en=0 for 3 cycles mid-packet:
- dst=OUT_LOCAL_PORT held;
- no pops while en=0;
- resumes in order afterward.
REQ-032 rst_n asserted after 2 of 4 flits popped: all outputs return to reset values; a fresh head after reset routes correctly.
REQ-033 With NOC_IU_ERR_CHK_EN: a body flit sent while IDLE is dropped with err=1; without the macro: err stays 0 and in_ready falls after 4 such flits.

Source files
------------

// File: rtl/noc_input_unit_pkg.sv
// Shared NoC input-unit definitions: output port codes, flit types, FSM states.
// Optional NOC_IU_ERR_CHK_EN protocol checking lives in noc_input_unit.
package noc_input_unit_pkg;

    localparam logic [2:0] EMPTY          = 3'd7;
    localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
    localparam logic [2:0] OUT_X1_PORT    = 3'd1;
    localparam logic [2:0] OUT_Y1_PORT    = 3'd2;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        ACTIVE
    } iu_state_e;

    function automatic logic is_head(input logic [1:0] t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

    // X is resolved before Y (dimension-ordered routing).
    function automatic logic [2:0] route_port(
        input logic       dx,
        input logic [1:0] dy,
        input logic       lx,
        input logic [1:0] ly
    );
        if (dx != lx) begin
            return OUT_X1_PORT;
        end
        if (dy != ly) begin
            return OUT_Y1_PORT;
        end
        return OUT_LOCAL_PORT;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit FIFO with wrap-bit pointers; full/empty come from the pointers alone.
// Push is refused when full regardless of a same-cycle pop.
module noc_flit_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLIT_W-1:0] wdata_i,
    output logic [FLIT_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q;
    logic [AW:0]       rptr_q;
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW])
                  && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/noc_input_unit.sv
// NoC router input unit: flit FIFO, route compute and per-packet FSM.
// Define NOC_IU_ERR_CHK_EN to drop stray body/tail flits and flag errors.
module noc_input_unit
    import noc_input_unit_pkg::*;
#(
    parameter int         FLIT_W  = 32,
    parameter int         DEPTH   = 4,
    parameter logic       LOCAL_X = 1'b0,
    parameter logic [1:0] LOCAL_Y = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic [2:0]        dst,
    output logic              dst_en,
    input  logic              grant,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              err
);

    logic [FLIT_W-1:0] front;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        ftype;

    iu_state_e         state_q, state_d;
    logic [2:0]        dst_q, dst_d;
    logic              dst_en_q, dst_en_d;
    logic              ov_q, ov_d;
    logic [FLIT_W-1:0] of_q, of_d;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign ftype    = front[FLIT_W-1 -: 2];

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_flit),
        .rdata_o (front),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef NOC_IU_ERR_CHK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        dst_en_d = 1'b0;
        ov_d     = 1'b0;
        of_d     = of_q;
        pop      = 1'b0;
`ifdef NOC_IU_ERR_CHK_EN
        err_d    = err_q;
`endif
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (!empty && is_head(ftype)) begin
                        state_d  = ROUTE;
                        dst_d    = route_port(front[FLIT_W-3],
                                              front[FLIT_W-4 -: 2],
                                              LOCAL_X, LOCAL_Y);
                        dst_en_d = 1'b1;
                    end
`ifdef NOC_IU_ERR_CHK_EN
                    else if (!empty) begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
`endif
                end
                ROUTE: begin
                    state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (grant && !empty) begin
                        pop  = 1'b1;
                        ov_d = 1'b1;
                        of_d = front;
`ifdef NOC_IU_ERR_CHK_EN
                        if (is_head(ftype)) begin
                            err_d = 1'b1;
                        end
`endif
                        if (is_tail(ftype)) begin
                            state_d = IDLE;
                            dst_d   = EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    dst_d   = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dst_q    <= EMPTY;
            dst_en_q <= 1'b0;
            ov_q     <= 1'b0;
            of_q     <= '0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            dst_en_q <= dst_en_d;
            ov_q     <= ov_d;
            of_q     <= of_d;
        end
    end

`ifdef NOC_IU_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dst       = dst_q;
    assign dst_en    = dst_en_q;
    assign out_valid = ov_q;
    assign out_flit  = of_q;

endmodule

// File: tb/tb_noc_input_unit.sv
// Self-checking bench for noc_input_unit: directed packet scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_noc_input_unit;
    import noc_input_unit_pkg::*;

    localparam int FW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic          grant = 1'b0;
    logic          in_ready;
    logic [2:0]    dst;
    logic          dst_en;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          err;

    always #5 clk = ~clk;

    noc_input_unit #(
        .FLIT_W  (FW),
        .DEPTH   (D),
        .LOCAL_X (1'b0),
        .LOCAL_Y (2'b00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .dst       (dst),
        .dst_en    (dst_en),
        .grant     (grant),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .err       (err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] mq[$];
    int            phase = 0;
    logic [2:0]    m_dst = EMPTY;
    logic          m_dst_en = 1'b0;
    logic          m_ov = 1'b0;
    logic [FW-1:0] m_of = '0;
    logic          m_err = 1'b0;
    bit            took = 1'b0;
    bit            mpush;
    logic [FW-1:0] mf;

    function automatic logic [2:0] m_route(input logic [FW-1:0] f);
        if (f[FW-3] != 1'b0) return OUT_X1_PORT;
        if (f[FW-4 -: 2] != 2'b00) return OUT_Y1_PORT;
        return OUT_LOCAL_PORT;
    endfunction

    function automatic bit m_hd(input logic [FW-1:0] f);
        return f[FW-1:FW-2] inside {2'b01, 2'b11};
    endfunction

    function automatic bit m_tl(input logic [FW-1:0] f);
        return f[FW-1:FW-2] inside {2'b10, 2'b11};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            phase = 0;
            m_dst = EMPTY;
            m_dst_en = 1'b0;
            m_ov = 1'b0;
            m_of = '0;
            m_err = 1'b0;
            took = 1'b0;
        end else begin
            mpush = in_valid && (mq.size() < D);
            m_dst_en = 1'b0;
            m_ov = 1'b0;
            if (en) begin
                if (phase == 0) begin
                    if (mq.size() > 0 && m_hd(mq[0])) begin
                        phase = 1;
                        m_dst = m_route(mq[0]);
                        m_dst_en = 1'b1;
                    end
`ifdef NOC_IU_ERR_CHK_EN
                    else if (mq.size() > 0) begin
                        mf = mq.pop_front();
                        m_err = 1'b1;
                    end
`endif
                end else if (phase == 1) begin
                    phase = 2;
                end else if (grant && mq.size() > 0) begin
                    mf = mq.pop_front();
                    m_ov = 1'b1;
                    m_of = mf;
`ifdef NOC_IU_ERR_CHK_EN
                    if (m_hd(mf)) m_err = 1'b1;
`endif
                    if (m_tl(mf)) begin
                        phase = 0;
                        m_dst = EMPTY;
                    end
                end
            end
            if (mpush) mq.push_back(in_flit);
            took = mpush;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [FW-1:0] outq[$];
    int            n_dst_en = 0;

    always @(negedge clk) begin
        chk("in_ready", in_ready, mq.size() < D);
        chk("dst", dst, m_dst);
        chk("dst_en", dst_en, m_dst_en);
        chk("out_valid", out_valid, m_ov);
        chk("err", err, m_err);
        if (m_ov) chk("out_flit", out_flit, m_of);
        if (out_valid) outq.push_back(out_flit);
        if (dst_en) n_dst_en++;
    end

    // ---------------- stimulus ----------------
    logic [FW-1:0] src[$];
    logic [FW-1:0] sent[$];
    logic [FW-1:0] dummy;
    int            pay = 0;
    int            gmode = 1;
    bit            emode = 0;
    bit            en_fix = 1;
    bit            vrand = 0;

    task automatic send(input logic [1:0] t, input logic dx,
                        input logic [1:0] dy);
        logic [FW-1:0] f;
        pay++;
        f = {t, dx, dy, pay[26:0]};
        src.push_back(f);
        sent.push_back(f);
    endtask

    task automatic pkt(input logic dx, input logic [1:0] dy, input int len);
        if (len <= 1) begin
            send(FT_SINGLE, dx, dy);
        end else begin
            send(FT_HEAD, dx, dy);
            for (int i = 0; i < len - 2; i++) send(FT_BODY, dx, dy);
            send(FT_TAIL, dx, dy);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (took && src.size() > 0) dummy = src.pop_front();
        took = 1'b0;
        in_valid = (src.size() > 0) && (!vrand || $urandom_range(3) != 0);
        in_flit = (src.size() > 0) ? src[0] : FW'($urandom);
        case (gmode)
            0: grant = 1'($urandom_range(1));
            1: grant = 1'b1;
            2: grant = ~grant;
            default: grant = 1'b0;
        endcase
        en = emode ? ($urandom_range(7) != 0) : en_fix;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_lits(input string nm);
        chk({nm, "_dst"}, dst, EMPTY);
        chk({nm, "_dst_en"}, dst_en, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_flit"}, out_flit, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_reset(input string nm);
        step();
        #2 rst_n = 1'b0;
        src.delete();
        in_valid = 1'b0;
        took = 1'b0;
        step();
        step();
        reset_lits(nm);
        #2 rst_n = 1'b1;
    endtask

    task automatic clear_q();
        outq.delete();
        sent.delete();
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_count"}, outq.size(), sent.size());
        for (int i = 0; i < sent.size() && i < outq.size(); i++)
            chk(nm, outq[i], sent[i]);
    endtask

    initial begin
        int n, de_at, ov_at, base, cnt;
        bit ok;
        en = 1'b1;
        run(2);
        reset_lits("reset");
        #2 rst_n = 1'b1;

        // single flit to x=1, grant held
        gmode = 1;
        clear_q();
        send(FT_SINGLE, 1'b1, 2'd0);
        de_at = 0;
        ov_at = 0;
        for (n = 1; n <= 12; n++) begin
            step();
            if (dst_en && de_at == 0) begin
                de_at = n;
                chk("single_dst", dst, OUT_X1_PORT);
            end
            if (out_valid && ov_at == 0) begin
                ov_at = n;
                chk("single_dst_after_pop", dst, EMPTY);
            end
        end
        chk("single_dst_en_cycle", de_at, 3);
        chk("single_out_valid_cycle", ov_at, 5);
        cmp_stream("single_stream");

        // 4-flit packet to (0,2) with toggling grant
        gmode = 2;
        clear_q();
        base = n_dst_en;
        pkt(1'b0, 2'd2, 4);
        run(30);
        chk("toggle_dst_en_pulses", n_dst_en - base, 1);
        cmp_stream("toggle_stream");

        // five flits with no grant
        gmode = 3;
        clear_q();
        pkt(1'b1, 2'd0, 5);
        run(10);
        chk("nogrant_in_ready", in_ready, 0);
        chk("nogrant_src_left", src.size(), 1);
        chk("nogrant_no_out", outq.size(), 0);
        gmode = 1;
        run(20);
        cmp_stream("nogrant_stream");

        // local packet frozen by en=0 mid-packet
        clear_q();
        pkt(1'b0, 2'd0, 4);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = out_valid;
        end
        chk("freeze_first_out", ok, 1);
        en_fix = 0;
        step();
        chk("freeze_dst0", dst, OUT_LOCAL_PORT);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) en_fix = 1;
            step();
            chk("freeze_dst", dst, OUT_LOCAL_PORT);
            chk("freeze_no_pop", out_valid, 0);
        end
        run(15);
        cmp_stream("freeze_stream");

        // reset after two of four flits
        clear_q();
        pkt(1'b1, 2'd1, 4);
        cnt = 0;
        for (int i = 0; i < 30 && cnt < 2; i++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("midreset_two_popped", cnt, 2);
        do_reset("midreset");
        clear_q();
        send(FT_SINGLE, 1'b0, 2'd1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = dst_en;
        end
        chk("postreset_dst_en", ok, 1);
        chk("postreset_dst", dst, OUT_Y1_PORT);
        run(8);
        cmp_stream("postreset_stream");

        // stray body flits while idle
        clear_q();
`ifdef NOC_IU_ERR_CHK_EN
        send(FT_BODY, 1'b0, 2'd0);
        run(6);
        chk("stray_err", err, 1);
        chk("stray_in_ready", in_ready, 1);
        chk("stray_dropped", outq.size(), 0);
`else
        for (int i = 0; i < 4; i++) send(FT_BODY, 1'b0, 2'd0);
        run(10);
        chk("stray_err", err, 0);
        chk("stray_in_ready", in_ready, 0);
        chk("stray_stalled", outq.size(), 0);
`endif
        do_reset("stray_reset");

        // randomized well-formed traffic
        clear_q();
        gmode = 0;
        emode = 1;
        vrand = 1;
        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 6)
                pkt(1'($urandom_range(1)), 2'($urandom_range(3)),
                    $urandom_range(1, 5));
            step();
        end
        gmode = 1;
        emode = 0;
        en_fix = 1;
        vrand = 0;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = (src.size() == 0) && (mq.size() == 0) && (phase == 0);
        end
        chk("random_drain", ok, 1);
        run(3);
        cmp_stream("random_stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
